// File: rtl/mem_noc_slave.sv
// Memory-bus target: byte-masked SRAM writes and word reads, one in-order response
// per request, with a credit counter that keeps the response FIFO from overflowing.
package mem_noc_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } mem_resp_t;
endpackage

module mem_noc_slave
  import mem_noc_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int RESP_DP = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_valid,
  output logic      req_ready,
  input  mem_req_t  req,
  output logic      resp_valid,
  input  logic      resp_ready,
  output mem_resp_t resp
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(RESP_DP);
  localparam logic [PW:0] CREDITS = (PW+1)'(RESP_DP);
  localparam logic [PW:0] ONE     = (PW+1)'(1);

  logic [AW-1:0]   idx;
  logic            accept;
  logic            pop;
  logic            s1_valid;
  logic            s1_wen;
  logic [3:0][7:0] s1_rdata;
  logic [31:0]     push_data;
  logic [PW:0]     outstanding;
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [PW:0]     fifo_count;
  logic [31:0]     fifo_mem [RESP_DP];

  assign idx       = req.addr[AW+1:2];
  assign req_ready = !rst && (outstanding < CREDITS);
  assign accept    = req_valid && req_ready;

  // One byte-wide RAM per lane so the mask maps onto independent write enables.
  // The lane read register is the stage-1 data; it is only reloaded on reads.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane [DEPTH];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (accept && req.wen && req.wmask[gi]) begin
        lane[idx] <= req.wdata[8*gi +: 8];
      end
      if (accept && !req.wen) begin
        rd_reg <= lane[idx];
      end
    end

    assign s1_rdata[gi] = rd_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_wen   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_wen <= req.wen;
      end
    end
  end

  // Writes answer with zero data; reads return the word fetched on the accept edge.
  assign push_data = s1_wen ? 32'h0 : s1_rdata;

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      fifo_mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (s1_valid) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  assign fifo_count = wr_ptr - rd_ptr;
  assign resp_valid = !rst && (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp.rdata = resp_valid ? fifo_mem[rd_ptr[PW-1:0]] : 32'h0;

  // Credits cover stage 1 plus the FIFO, so an accepted request always has a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + ONE;
        2'b01:   outstanding <= outstanding - ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_noc_slave.sv
// Directed bench for mem_noc_slave: a reference memory and a response scoreboard
// are updated on every observed handshake and checked against the DUT outputs.
module tb_mem_noc_slave;
  import mem_noc_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int RESP_DP = 4;
  localparam int AW      = $clog2(DEPTH);

  logic      clk = 1'b0;
  logic      rst;
  logic      req_valid;
  logic      req_ready;
  mem_req_t  req;
  logic      resp_valid;
  logic      resp_ready;
  mem_resp_t resp;

  always #5 clk = ~clk;

  mem_noc_slave #(.DEPTH(DEPTH), .RESP_DP(RESP_DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req        (req),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp       (resp)
  );

  typedef struct {
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  int cyc    = 0;
  int n_vec  = 0;
  int n_mis  = 0;
  int n_acc  = 0;
  int n_resp = 0;
  int n_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that took the request.
  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic w);
    int budget = 64;
    req.addr  = a;
    req.wdata = d;
    req.wmask = m;
    req.wen   = w;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      budget--;
    end while (!req_ready && budget > 0);
    chk("send_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 64;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Monitor: samples mid-cycle, i.e. the values the next rising edge will see.
  initial begin
    exp_t          e;
    logic [AW-1:0] mi;
    bit            prev_rv;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(!rst && sb.size() < RESP_DP));
      if (rst) begin
        n_drop += sb.size();
        sb.delete();
        prev_rv = 1'b0;
      end else begin
        if (resp_valid && !prev_rv) begin
          if (sb.size() == 0) chk("spurious_valid", 32'(resp_valid), 32'd0);
          else chk("latency", 32'(cyc - sb[0].acc), 32'd2);
        end
        prev_rv = resp_valid;
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            chk("extra_resp", 32'(resp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rdata", resp.rdata, e.rdata);
            n_resp++;
            $display("resp %0d: rdata=%h (accepted cycle %0d)", n_resp, resp.rdata, e.acc);
          end
        end
        if (req_valid && req_ready) begin
          mi = req.addr[AW+1:2];
          if (req.wen) begin
            for (int b = 0; b < 4; b++) begin
              if (req.wmask[b]) mdl[mi][8*b +: 8] = req.wdata[8*b +: 8];
            end
            e.rdata = 32'h0;
          end else begin
            e.rdata = mdl[mi];
          end
          e.acc = cyc;
          sb.push_back(e);
          n_acc++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int base;
    logic [31:0] d;
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    req        = '0;

    // Reset hold and release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_resp_valid", 32'(resp_valid), 32'd0);
    chk("rel_resp", resp.rdata, 32'h0);
    tick();

    // Write then read back-to-back
    send(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    send(32'h10, 32'h0, 4'h0, 1'b0);
    wait_drain();

    // Partial write, low-bit and high-bit aliasing, empty mask
    send(32'h10, 32'h11223344, 4'h5, 1'b1);
    send(32'h13, 32'h0, 4'h0, 1'b0);
    send(32'h10 + 4*DEPTH, 32'h0, 4'h0, 1'b0);
    send(32'h8000_0010, 32'h0, 4'h0, 1'b0);
    send(32'h10, 32'hFFFFFFFF, 4'h0, 1'b1);
    send(32'h10, 32'h0, 4'h0, 1'b0);
    wait_drain();

    // Sustained read-after-write traffic at one request per cycle
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      send(32'h40 + 32'(4*i), d, 4'hF, 1'b1);
      send(32'h40 + 32'(4*i), 32'h0, 4'h0, 1'b0);
    end
    chk("throughput", 32'(cyc - c0), 32'd12);
    wait_drain();

    // Backpressure: fill the credits, then drain while streaming
    for (int i = 0; i < 6; i++) send(32'h100 + 32'(4*i), $urandom, 4'hF, 1'b1);
    wait_drain();
    resp_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(4*i), 32'h0, 4'h0, 1'b0);
    req.addr  = 32'h110;
    req.wen   = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    chk("bp_accepted", 32'(n_acc - base), 32'd4);
    tick();
    resp_ready = 1'b1;
    send(32'h110, 32'h0, 4'h0, 1'b0);
    send(32'h114, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(4*(i % 6)), 32'h0, 4'h0, 1'b0);
    wait_drain();
    chk("bp_total", 32'(n_resp + n_drop), 32'(n_acc));

    // Reset with responses queued; the last accepted write must survive
    resp_ready = 1'b0;
    send(32'h100, 32'h0, 4'h0, 1'b0);
    send(32'h104, 32'h0, 4'h0, 1'b0);
    send(32'h108, 32'h0, 4'h0, 1'b0);
    send(32'h200, 32'hCAFEF00D, 4'hF, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp", resp.rdata, 32'h0);
    tick();
    resp_ready = 1'b1;
    send(32'h200, 32'h0, 4'h0, 1'b0);
    send(32'h10, 32'h0, 4'h0, 1'b0);
    wait_drain();
    chk("total", 32'(n_resp + n_drop), 32'(n_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
